mfp_uart_rx_fifo: RTL

Buffered UART receive front end for the ESP Wi-Fi link. It oversamples the WIFI_RX serial line 16×, reconstructs 8-bit frames, and validates the start, stop and optional parity bits. Accepted bytes are queued in a first-word-fall-through FIFO. It sits directly upstream of the AHB GPIO block, which reads the head byte through its memory-mapped PMOD port and pops it on read, so bursts from the Wi-Fi module are no longer lost between CPU polls.

---
 rtl/mfp_uart_pkg.sv | 27 ++
 rtl/mfp_sync_fifo.sv | 66 ++++++
 rtl/mfp_uart_rx_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_uart_pkg.sv
// Shared definitions for the ESP Wi-Fi UART receive path: receiver state
// encoding, oversampling constants and the baud divider calculation.
package mfp_uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START    = 3'd1,
        DATA     = 3'd2,
        PARITY   = 3'd3,
        STOP     = 3'd4,
        ERR_WAIT = 3'd5
    } uart_state_t;

    // Clocks per oversample tick, rounded to nearest, never below one.
    function automatic int calc_div(input int clk_hz, input int baud);
        int d;
        d = (clk_hz + (baud * 8)) / (baud * OVERSAMPLE);
        if (d < 1) begin
            d = 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/mfp_sync_fifo.sv
// First-word-fall-through byte FIFO. The head entry is presented on o_data
// whenever the FIFO is non-empty (zero otherwise). An explicit occupancy
// counter keeps full and empty unambiguous while pointers wrap freely.
// Handshake: a push is accepted when not full, or when full and a pop is
// performed in the same cycle; a pop is performed only when non-empty.
module mfp_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       HCLK,
    input  logic                       HRESETn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_count   = r_count;
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because o_data is gated by empty.
    always_ff @(posedge HCLK) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mfp_uart_rx_fifo.sv
// Buffered UART receiver for the ESP Wi-Fi link: 2-flop synchronizer,
// 16x oversampling tick generator, frame FSM and a FWFT byte FIFO read by
// the AHB GPIO block. Optional even parity (8E1) is enabled by defining
// MFP_UART_RX_PARITY_EN; otherwise frames are 8N1 and parity_err is 0.
// pop removes the head byte on the clock edge it is sampled high; it is
// ignored while byte_ready is low.
module mfp_uart_rx_fifo
    import mfp_uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          rx,
    input  logic                          pop,
    input  logic                          clr_err,
    output logic [7:0]                    byte_data,
    output logic                          byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overflow,
    output uart_state_t                   dbg_state
);

    localparam int DIV    = calc_div(CLK_HZ, BAUD);
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_LAST = 4'(MID_SAMPLE - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic [TICK_W-1:0] r_tick_cnt;
    uart_state_t       r_state;
    logic [3:0]        r_os_cnt;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_push;
    logic              r_frame_err;
    logic              r_overflow;

    logic              w_rx;
    logic              w_tick;
    logic              w_sample_mid;
    logic              w_sample_bit;
    uart_state_t       w_state_next;
    logic [3:0]        w_os_next;
    logic [2:0]        w_bit_next;
    logic [7:0]        w_shift_next;
    logic              w_push_next;
    logic              w_frame_set;
    logic              w_ovf_set;
    logic              w_full;
    logic              w_empty;

`ifdef MFP_UART_RX_PARITY_EN
    logic              r_par_bad;
    logic              r_parity_err;
    logic              w_par_bad_next;
    logic              w_par_set;
`endif

    assign w_rx         = r_sync2;
    assign w_tick       = (r_state != IDLE) && (r_tick_cnt == TICK_LAST);
    assign w_sample_mid = w_tick && (r_os_cnt == MID_LAST);
    assign w_sample_bit = w_tick && (r_os_cnt == OS_LAST);
    assign dbg_state    = r_state;

    // Bring the asynchronous serial line into the HCLK domain; idles high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Oversample tick divider, held at zero in IDLE so every frame starts fresh.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_tick_cnt <= '0;
        end else if ((r_state == IDLE) || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TICK_W'(1);
        end
    end

    // Frame FSM next-state, sampling and byte acceptance decisions.
    always_comb begin
        w_state_next = r_state;
        w_os_next    = r_os_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_push_next  = 1'b0;
        w_frame_set  = 1'b0;
`ifdef MFP_UART_RX_PARITY_EN
        w_par_bad_next = r_par_bad;
        w_par_set      = 1'b0;
`endif
        if (w_tick) begin
            w_os_next = r_os_cnt + 4'd1;
        end
        case (r_state)
            IDLE: begin
                w_os_next  = 4'd0;
                w_bit_next = 3'd0;
`ifdef MFP_UART_RX_PARITY_EN
                w_par_bad_next = 1'b0;
`endif
                if (!w_rx) begin
                    w_state_next = START;
                end
            end
            START: begin
                if (w_sample_mid) begin
                    w_os_next    = 4'd0;
                    w_state_next = w_rx ? IDLE : DATA;
                end
            end
            DATA: begin
                if (w_sample_bit) begin
                    w_os_next    = 4'd0;
                    w_shift_next = {w_rx, r_shift[7:1]};
                    w_bit_next   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef MFP_UART_RX_PARITY_EN
                        w_state_next = PARITY;
`else
                        w_state_next = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef MFP_UART_RX_PARITY_EN
                if (w_sample_bit) begin
                    w_os_next      = 4'd0;
                    w_par_bad_next = (w_rx != (^r_shift));
                    w_state_next   = STOP;
                end
`else
                w_state_next = IDLE;
`endif
            end
            STOP: begin
                if (w_sample_bit) begin
                    w_os_next = 4'd0;
`ifdef MFP_UART_RX_PARITY_EN
                    w_par_set = r_par_bad;
`endif
                    if (w_rx) begin
                        w_state_next = IDLE;
`ifdef MFP_UART_RX_PARITY_EN
                        w_push_next  = !r_par_bad;
`else
                        w_push_next  = 1'b1;
`endif
                    end else begin
                        w_state_next = ERR_WAIT;
                        w_frame_set  = 1'b1;
                    end
                end
            end
            ERR_WAIT: begin
                if (w_rx) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Frame FSM and datapath registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state   <= IDLE;
            r_os_cnt  <= 4'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_push    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_os_cnt  <= w_os_next;
            r_bit_idx <= w_bit_next;
            r_shift   <= w_shift_next;
            r_push    <= w_push_next;
        end
    end

`ifdef MFP_UART_RX_PARITY_EN
    // Parity verdict for the current frame and its sticky error flag.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_par_bad <= w_par_bad_next;
            if (w_par_set) begin
                r_parity_err <= 1'b1;
            end else if (clr_err) begin
                r_parity_err <= 1'b0;
            end
        end
    end
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    // A push into a full FIFO is lost unless a pop frees a slot that cycle.
    assign w_ovf_set = r_push && w_full && !pop;

    // Sticky framing and overflow flags; a new error wins over clr_err.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_frame_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_frame_set) begin
                r_frame_err <= 1'b1;
            end else if (clr_err) begin
                r_frame_err <= 1'b0;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
    assign byte_ready = !w_empty;

    mfp_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .i_push  (r_push),
        .i_data  (r_shift),
        .i_pop   (pop),
        .o_data  (byte_data),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule
